// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetches 5-instruction bundles and steps through them one index per cycle
module instr_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUNDLE_BYTES = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_valid,
  input  logic [159:0] imem_rdata,
  output logic [159:0] odata_bundle,
  output logic [3:0]   ocount_inst,
  output logic         ovalid,
  output logic [31:0]  opc
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ISSUE} state_t;
  state_t state;
  logic [31:0] base, rpc, tgt, nxt;
  assign rpc = {redirect_pc[31:2], 2'b00};
  assign tgt = redirect ? rpc : base;
  assign nxt = redirect ? rpc : base + 32'(BUNDLE_BYTES);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      base <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      odata_bundle <= '0;
      ocount_inst <= '0;
      ovalid <= 1'b0;
      opc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
          base <= tgt;
          imem_addr <= tgt;
        end
        FETCH: begin
          if (redirect) begin
            base <= rpc;
            if (imem_valid) imem_addr <= rpc;
            else begin
              state <= DRAIN;
              imem_req <= 1'b0;
            end
          end else if (imem_valid) begin
            state <= ISSUE;
            imem_req <= 1'b0;
            odata_bundle <= imem_rdata;
            ocount_inst <= '0;
            opc <= base;
            ovalid <= 1'b1;
          end
        end
        // one stale response is still in flight; swallow it before refetching
        DRAIN: begin
          base <= tgt;
          if (imem_valid) begin
            state <= FETCH;
            imem_req <= 1'b1;
            imem_addr <= tgt;
          end
        end
        ISSUE: begin
          if (redirect || (!stall && ocount_inst == 4'd4)) begin
            state <= FETCH;
            imem_req <= 1'b1;
            ovalid <= 1'b0;
            base <= nxt;
            imem_addr <= nxt;
            ocount_inst <= '0;
            opc <= nxt;
          end else if (!stall) begin
            ocount_inst <= ocount_inst + 4'd1;
            opc <= opc + 32'd4;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed stimulus with a queue scoreboard checking every issued instruction
module tb_instr_fetch_seq;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, ovalid;
  logic [31:0] imem_addr, opc;
  logic [159:0] imem_rdata = '0, odata_bundle;
  logic [3:0] ocount_inst;
  typedef struct {logic [3:0] cnt; logic [31:0] pc; logic [31:0] word;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .odata_bundle(odata_bundle), .ocount_inst(ocount_inst), .ovalid(ovalid), .opc(opc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [159:0] bundle(input logic [31:0] a);
    return {w(a + 32'd16), w(a + 32'd12), w(a + 32'd8), w(a + 32'd4), w(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] b, input int c);
    exp_t e;
    e.cnt = 4'(c);
    e.pc = b + 32'(4 * c);
    e.word = w(e.pc);
    sb.push_back(e);
  endtask

  task automatic push_bundle(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) push(b, i);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp, input string name);
    int n = 0;
    while (!imem_req && n < 50) begin
      step;
      n++;
    end
    chk({name, "_seen"}, 32'(imem_req), 32'd1);
    chk({name, "_addr"}, imem_addr, exp);
  endtask

  task automatic serve(input int lat, input logic [31:0] exp, input string name);
    wait_req(exp, name);
    repeat (lat) step;
    imem_valid = 1'b1;
    imem_rdata = bundle(imem_addr);
    step;
    imem_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && ovalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue got cnt=%0d pc=%h expected no issue", ocount_inst, opc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_cnt", 32'(ocount_inst), 32'(e.cnt));
        chk("issue_pc", opc, e.pc);
        chk("issue_word", 32'(odata_bundle >> (32 * ocount_inst)), e.word);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    #3 rst = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_cnt", 32'(ocount_inst), 32'd0);
    chk("rst_opc", opc, 32'h0);
    chk("rst_data", 32'(odata_bundle), 32'h0);
    step;
    step;
    rst = 1'b1;
    push_bundle(32'h0, 5);
    serve(1, 32'h0, "first");
    // stall holds index 2 across three sampled edges
    push(32'h14, 0);
    push(32'h14, 1);
    repeat (4) push(32'h14, 2);
    push(32'h14, 3);
    push(32'h14, 4);
    serve(1, 32'h14, "second");
    step;
    step;
    stall = 1'b1;
    repeat (3) step;
    stall = 1'b0;
    // redirect in ISSUE at index 1
    push(32'h28, 0);
    push(32'h28, 1);
    serve(1, 32'h28, "third");
    step;
    chk("pre_redir_cnt", 32'(ocount_inst), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step;
    redirect = 1'b0;
    chk("redir_ovalid", 32'(ovalid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    push_bundle(32'h100, 5);
    serve(2, 32'h100, "redir");
    // redirect while waiting: stale response must be dropped
    wait_req(32'h114, "stale");
    step;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step;
    redirect = 1'b0;
    chk("drain_req", 32'(imem_req), 32'd0);
    step;
    chk("drain_req2", 32'(imem_req), 32'd0);
    step;
    imem_valid = 1'b1;
    imem_rdata = bundle(32'h114);
    step;
    imem_valid = 1'b0;
    push_bundle(32'h200, 5);
    serve(1, 32'h200, "after_drain");
    // redirect coinciding with the response
    wait_req(32'h214, "coincide");
    step;
    imem_valid = 1'b1;
    imem_rdata = bundle(32'h214);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step;
    imem_valid = 1'b0;
    redirect = 1'b0;
    chk("coin_req", 32'(imem_req), 32'd1);
    chk("coin_addr", imem_addr, 32'h40);
    chk("coin_ovalid", 32'(ovalid), 32'd0);
    push_bundle(32'h40, 4);
    serve(1, 32'h40, "x40");
    repeat (3) step;
    chk("pre_rst_cnt", 32'(ocount_inst), 32'd3);
    // asynchronous reset mid-issue
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_ovalid", 32'(ovalid), 32'd0);
    chk("arst_cnt", 32'(ocount_inst), 32'd0);
    chk("arst_opc", opc, 32'h0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_data", 32'(odata_bundle), 32'h0);
    imem_valid = 1'b1;
    imem_rdata = bundle(32'h500);
    step;
    rst = 1'b1;
    step;
    imem_valid = 1'b0;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_ovalid", 32'(ovalid), 32'd0);
    push_bundle(32'h0, 5);
    serve(1, 32'h0, "restart");
    repeat (10) step;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
